// File: rtl/hazard_unit_if.sv
// Pipeline-side bundle for the hazard unit: ID/EX/MEM/WB register fields in, stall/flush/forward controls out.
interface hazard_unit_if #(
  parameter int unsigned CNT_W = 16
);

  // Register-file addresses and use flags of the instruction sitting in ID
  logic [4:0]       id_addr_a;
  logic [4:0]       id_addr_b;
  logic             id_uses_a;
  logic             id_uses_b;

  // ID/EX register outputs
  logic [4:0]       ex_addr_a;
  logic [4:0]       ex_addr_b;
  logic [4:0]       ex_addr_d;
  logic             ex_reg_wen;
  logic [1:0]       ex_wbsel;
  logic             ex_pcsel;

  // Downstream destinations
  logic [4:0]       mem_addr_d;
  logic             mem_reg_wen;
  logic [4:0]       wb_addr_d;
  logic             wb_reg_wen;

  // Debug counter control
  logic             cnt_clr;

  // Pipeline steering controls
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;

  // Performance counters
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline datapath side
  modport master (
    output id_addr_a, id_addr_b, id_uses_a, id_uses_b,
    output ex_addr_a, ex_addr_b, ex_addr_d, ex_reg_wen, ex_wbsel, ex_pcsel,
    output mem_addr_d, mem_reg_wen, wb_addr_d, wb_reg_wen, cnt_clr,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush,
    input  fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  // Hazard unit side
  modport slave (
    input  id_addr_a, id_addr_b, id_uses_a, id_uses_b,
    input  ex_addr_a, ex_addr_b, ex_addr_d, ex_reg_wen, ex_wbsel, ex_pcsel,
    input  mem_addr_d, mem_reg_wen, wb_addr_d, wb_reg_wen, cnt_clr,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush,
    output fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall sequencing, branch flush, operand forwarding, debug counters.
module hazard_unit #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter logic [1:0]  WBSEL_MEM         = 2'b00,
  parameter int unsigned CNT_W             = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  hazard_unit_if.slave bus
);

  localparam int unsigned REM_W    = 2;
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic             lu_hit;
  logic             stall;
  logic             flush_if;
  logic             flush_ex;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  // Forwarding source for one EX operand; EX/MEM beats MEM/WB, x0 never forwarded
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       mem_wen,
                                         input logic [4:0] mem_rd,
                                         input logic       wb_wen,
                                         input logic [4:0] wb_rd);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_wen && (mem_rd != 5'd0) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_wen && (wb_rd != 5'd0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Load in EX whose destination is read by the instruction in ID
  always_comb begin
    lu_hit = bus.ex_reg_wen && (bus.ex_wbsel == WBSEL_MEM) && (bus.ex_addr_d != 5'd0) &&
             ((bus.id_uses_a && (bus.ex_addr_d == bus.id_addr_a)) ||
              (bus.id_uses_b && (bus.ex_addr_d == bus.id_addr_b)));
  end

  // Next-state and stall/flush decode; a taken branch always overrides stalling
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    stall    = 1'b0;
    flush_if = 1'b0;
    flush_ex = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.ex_pcsel) begin
          flush_if = 1'b1;
          flush_ex = 1'b1;
        end else if (lu_hit) begin
          stall    = 1'b1;
          flush_ex = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = LU_STALL;
            rem_d   = REM_INIT;
          end
        end
      end
      LU_STALL: begin
        if (bus.ex_pcsel) begin
          flush_if = 1'b1;
          flush_ex = 1'b1;
          state_d  = RUN;
          rem_d    = '0;
        end else begin
          stall    = 1'b1;
          flush_ex = 1'b1;
          if (rem_q <= REM_W'(1)) begin
            state_d = RUN;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - REM_W'(1);
          end
        end
      end
      default: begin
        state_d = RUN;
        rem_d   = '0;
      end
    endcase
  end

  // Operand forwarding selects
  always_comb begin
    fwd_a = fwd_sel(bus.ex_addr_a, bus.mem_reg_wen, bus.mem_addr_d, bus.wb_reg_wen, bus.wb_addr_d);
    fwd_b = fwd_sel(bus.ex_addr_b, bus.mem_reg_wen, bus.mem_addr_d, bus.wb_reg_wen, bus.wb_addr_d);
  end

  // FSM state and remaining-bubble register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Saturating stall/flush cycle counters; clear beats increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_if && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // Controls are combinational and held inactive while reset is asserted
  always_comb begin
    bus.pc_stall    = reset_n & stall;
    bus.if_id_stall = reset_n & stall;
    bus.if_id_flush = reset_n & flush_if;
    bus.id_ex_flush = reset_n & flush_ex;
    bus.fwd_a_sel   = reset_n ? fwd_a : FWD_RF;
    bus.fwd_b_sel   = reset_n ? fwd_b : FWD_RF;
    bus.stall_cnt   = stall_cnt_q;
    bus.flush_cnt   = flush_cnt_q;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: three configurations share stimulus, each checked against a behavioural model.
module tb_hazard_unit;

  localparam int unsigned N_INST = 3;

  typedef struct packed {
    logic       reset_n;
    logic [4:0] id_addr_a;
    logic [4:0] id_addr_b;
    logic       id_uses_a;
    logic       id_uses_b;
    logic [4:0] ex_addr_a;
    logic [4:0] ex_addr_b;
    logic [4:0] ex_addr_d;
    logic       ex_reg_wen;
    logic [1:0] ex_wbsel;
    logic       ex_pcsel;
    logic [4:0] mem_addr_d;
    logic       mem_reg_wen;
    logic [4:0] wb_addr_d;
    logic       wb_reg_wen;
    logic       cnt_clr;
  } stim_t;

  typedef struct packed {
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
  } out_t;

  logic  clk;
  logic  reset_n;
  stim_t st;
  out_t  act [N_INST];

  out_t  exp_q [N_INST][$];
  int    tests;
  int    fails;
  int    cyc;

  // Model state: bubbles still owed, counter values
  int    m_bub [N_INST];
  int    m_sc  [N_INST];
  int    m_fc  [N_INST];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign reset_n = st.reset_n;

  // Instance g: LOAD_STALL_CYCLES = g+1; the last one also has 2-bit counters
  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    localparam int unsigned LSC = g + 1;
    localparam int unsigned CW  = (g == N_INST - 1) ? 2 : 16;

    hazard_unit_if #(.CNT_W(CW)) bus ();

    assign bus.id_addr_a   = st.id_addr_a;
    assign bus.id_addr_b   = st.id_addr_b;
    assign bus.id_uses_a   = st.id_uses_a;
    assign bus.id_uses_b   = st.id_uses_b;
    assign bus.ex_addr_a   = st.ex_addr_a;
    assign bus.ex_addr_b   = st.ex_addr_b;
    assign bus.ex_addr_d   = st.ex_addr_d;
    assign bus.ex_reg_wen  = st.ex_reg_wen;
    assign bus.ex_wbsel    = st.ex_wbsel;
    assign bus.ex_pcsel    = st.ex_pcsel;
    assign bus.mem_addr_d  = st.mem_addr_d;
    assign bus.mem_reg_wen = st.mem_reg_wen;
    assign bus.wb_addr_d   = st.wb_addr_d;
    assign bus.wb_reg_wen  = st.wb_reg_wen;
    assign bus.cnt_clr     = st.cnt_clr;

    hazard_unit #(
      .LOAD_STALL_CYCLES(LSC),
      .WBSEL_MEM        (2'b00),
      .CNT_W            (CW)
    ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
    );

    assign act[g] = '{pc_stall:    bus.pc_stall,
                      if_id_stall: bus.if_id_stall,
                      if_id_flush: bus.if_id_flush,
                      id_ex_flush: bus.id_ex_flush,
                      fwd_a_sel:   bus.fwd_a_sel,
                      fwd_b_sel:   bus.fwd_b_sel,
                      stall_cnt:   16'(bus.stall_cnt),
                      flush_cnt:   16'(bus.flush_cnt)};
  end

  function automatic int lsc_of(input int g);
    return g + 1;
  endfunction

  function automatic int cmax_of(input int g);
    return (g == N_INST - 1) ? 3 : 65535;
  endfunction

  function automatic logic [1:0] ref_fwd(input stim_t s, input logic [4:0] src);
    if (s.mem_reg_wen && s.mem_addr_d != 0 && s.mem_addr_d == src) return 2'b01;
    if (s.wb_reg_wen && s.wb_addr_d != 0 && s.wb_addr_d == src) return 2'b10;
    return 2'b00;
  endfunction

  // Expected outputs for this cycle, then advance the model to the next edge
  task automatic model_cycle(input int g, input stim_t s, output out_t e);
    bit hit, stall, flush;
    e = '0;
    if (!s.reset_n) begin
      m_bub[g] = 0;
      m_sc[g]  = 0;
      m_fc[g]  = 0;
    end else begin
      hit = s.ex_reg_wen && s.ex_wbsel == 2'b00 && s.ex_addr_d != 0 &&
            ((s.id_uses_a && s.ex_addr_d == s.id_addr_a) ||
             (s.id_uses_b && s.ex_addr_d == s.id_addr_b));
      stall = 0;
      flush = 0;
      if (s.ex_pcsel) begin
        flush    = 1;
        m_bub[g] = 0;
      end else if (m_bub[g] > 0) begin
        stall    = 1;
        m_bub[g] = m_bub[g] - 1;
      end else if (hit) begin
        stall    = 1;
        m_bub[g] = lsc_of(g) - 1;
      end
      e.pc_stall    = stall;
      e.if_id_stall = stall;
      e.if_id_flush = flush;
      e.id_ex_flush = stall || flush;
      e.fwd_a_sel   = ref_fwd(s, s.ex_addr_a);
      e.fwd_b_sel   = ref_fwd(s, s.ex_addr_b);
      e.stall_cnt   = 16'(m_sc[g]);
      e.flush_cnt   = 16'(m_fc[g]);
      if (s.cnt_clr) begin
        m_sc[g] = 0;
        m_fc[g] = 0;
      end else begin
        if (stall && m_sc[g] < cmax_of(g)) m_sc[g] = m_sc[g] + 1;
        if (flush && m_fc[g] < cmax_of(g)) m_fc[g] = m_fc[g] + 1;
      end
    end
  endtask

  // Apply one cycle of stimulus just after the edge and queue expectations
  task automatic drive(input stim_t s);
    out_t e;
    @(posedge clk);
    #1;
    st = s;
    cyc++;
    for (int g = 0; g < N_INST; g++) begin
      model_cycle(g, s, e);
      exp_q[g].push_back(e);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.reset_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t load_use(input logic [4:0] rd);
    stim_t s;
    s = idle();
    s.ex_reg_wen = 1'b1;
    s.ex_wbsel   = 2'b00;
    s.ex_addr_d  = rd;
    s.id_addr_a  = rd;
    s.id_uses_a  = 1'b1;
    return s;
  endfunction

  // Monitor: compare every instance's outputs mid-cycle against the queued expectation
  always @(negedge clk) begin
    for (int g = 0; g < N_INST; g++) begin
      if (exp_q[g].size() > 0) begin
        out_t e;
        e = exp_q[g].pop_front();
        tests++;
        if (act[g] !== e) begin
          fails++;
          $display("FAIL inst%0d cycle %0d: got stl=%b ifs=%b iff=%b exf=%b fa=%b fb=%b sc=%0d fc=%0d, want stl=%b ifs=%b iff=%b exf=%b fa=%b fb=%b sc=%0d fc=%0d",
                   g, cyc, act[g].pc_stall, act[g].if_id_stall, act[g].if_id_flush, act[g].id_ex_flush,
                   act[g].fwd_a_sel, act[g].fwd_b_sel, act[g].stall_cnt, act[g].flush_cnt,
                   e.pc_stall, e.if_id_stall, e.if_id_flush, e.id_ex_flush,
                   e.fwd_a_sel, e.fwd_b_sel, e.stall_cnt, e.flush_cnt);
        end
      end
    end
  end

  initial begin
    stim_t s;
    tests = 0;
    fails = 0;
    cyc   = 0;
    for (int g = 0; g < N_INST; g++) begin
      m_bub[g] = 0;
      m_sc[g]  = 0;
      m_fc[g]  = 0;
    end
    st = '0;

    // Reset with a live load-use pattern on the inputs: outputs must stay 0
    s = load_use(5'd5);
    s.reset_n = 1'b0;
    s.ex_pcsel = 1'b1;
    drive(s);
    drive(s);
    drive(idle());

    // Single load-use hazard on x5, then quiet cycles
    drive(load_use(5'd5));
    repeat (4) drive(idle());

    // rs2 variant
    s = load_use(5'd9);
    s.id_uses_a = 1'b0;
    s.id_addr_b = 5'd9;
    s.id_uses_b = 1'b1;
    drive(s);
    repeat (4) drive(idle());

    // Branch taken together with a load-use hit
    s = load_use(5'd5);
    s.ex_pcsel = 1'b1;
    drive(s);
    repeat (2) drive(idle());

    // Branch during a multi-cycle stall
    drive(load_use(5'd3));
    s = idle();
    s.ex_pcsel = 1'b1;
    drive(s);
    repeat (3) drive(idle());

    // Forwarding priority and x0 exclusion
    s = idle();
    s.ex_addr_a = 5'd7;  s.ex_addr_b = 5'd7;
    s.mem_addr_d = 5'd7; s.mem_reg_wen = 1'b1;
    s.wb_addr_d = 5'd7;  s.wb_reg_wen = 1'b1;
    drive(s);
    s.mem_reg_wen = 1'b0;
    drive(s);
    s.ex_addr_a = 5'd0;  s.ex_addr_b = 5'd0;
    s.mem_addr_d = 5'd0; s.wb_addr_d = 5'd0;
    s.mem_reg_wen = 1'b1;
    s.wb_reg_wen = 1'b1;
    drive(s);

    // Non-hazards: load to x0, and a non-load write-back select
    s = load_use(5'd0);
    drive(s);
    s = load_use(5'd5);
    s.ex_wbsel = 2'b01;
    drive(s);
    s = load_use(5'd5);
    s.ex_reg_wen = 1'b0;
    drive(s);

    // Hold a hit long enough to saturate the narrow counters, then clear
    repeat (6) drive(load_use(5'd4));
    repeat (3) drive(idle());
    s = idle();
    s.cnt_clr = 1'b1;
    drive(s);
    s = idle();
    s.cnt_clr = 1'b1;
    s.ex_pcsel = 1'b1;
    drive(s);
    drive(idle());

    // Reset asserted while a multi-cycle stall is in progress
    drive(load_use(5'd6));
    s = idle();
    s.reset_n = 1'b0;
    drive(s);
    drive(s);
    repeat (3) drive(idle());

    // Randomised traffic over a small register window so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      s.reset_n     = ($urandom_range(0, 199) != 0);
      s.id_addr_a   = 5'($urandom_range(0, 3));
      s.id_addr_b   = 5'($urandom_range(0, 3));
      s.id_uses_a   = 1'($urandom);
      s.id_uses_b   = 1'($urandom);
      s.ex_addr_a   = 5'($urandom_range(0, 3));
      s.ex_addr_b   = 5'($urandom_range(0, 3));
      s.ex_addr_d   = 5'($urandom_range(0, 3));
      s.ex_reg_wen  = ($urandom_range(0, 3) != 0);
      s.ex_wbsel    = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'($urandom);
      s.ex_pcsel    = ($urandom_range(0, 7) == 0);
      s.mem_addr_d  = 5'($urandom_range(0, 3));
      s.mem_reg_wen = 1'($urandom);
      s.wb_addr_d   = 5'($urandom_range(0, 3));
      s.wb_reg_wen  = 1'($urandom);
      s.cnt_clr     = ($urandom_range(0, 63) == 0);
      drive(s);
    end
    drive(idle());

    // Drain: every queued expectation must have been consumed
    @(negedge clk);
    #1;
    for (int g = 0; g < N_INST; g++) begin
      tests++;
      if (exp_q[g].size() != 0) begin
        fails++;
        $display("FAIL drain inst%0d: %0d left, want 0", g, exp_q[g].size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
